// File: rtl/alu_operand_stage.sv
// Operand-issue stage feeding the ALU: selects A/B on capture, cleans shift amounts,
// and buffers up to two entries (main + skid) so backpressure never costs throughput.
module alu_operand_stage #(
    parameter int TAG_W       = 4,
    parameter int CHECK_SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_alufun,
    input  logic [31:0]      in_rs,
    input  logic [31:0]      in_rt,
    input  logic [31:0]      in_imm,
    input  logic [4:0]       in_shamt,
    input  logic             in_srca,
    input  logic             in_srcb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic [5:0]       ALUFun,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_illegal,
    output logic [15:0]      issue_cnt
);

    logic             main_valid;
    logic             skid_valid;
    logic [31:0]      skid_a;
    logic [31:0]      skid_b;
    logic [5:0]       skid_fun;
    logic [TAG_W-1:0] skid_tag;

    logic [31:0] sel_a;
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    logic        is_shift;
    logic        legal_shift;
    logic        illegal;
    logic        accept;
    logic        issue;

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign issue     = main_valid & out_ready;

    // Shift ops only look at the low five bits of A, so keep the upper bits clean for the shifter.
    always_comb begin
        sel_a       = in_srca ? {27'b0, in_shamt} : in_rs;
        cap_b       = in_srcb ? in_imm : in_rt;
        is_shift    = (in_alufun[5:4] == 2'b10);
        legal_shift = (in_alufun == 6'b100000) || (in_alufun == 6'b100001) ||
                      (in_alufun == 6'b100011);
        illegal     = (CHECK_SHIFT != 0) && is_shift && !legal_shift;
        cap_a       = is_shift ? {27'b0, sel_a[4:0]} : sel_a;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid  <= 1'b0;
            skid_valid  <= 1'b0;
            A           <= '0;
            B           <= '0;
            ALUFun      <= '0;
            out_tag     <= '0;
            skid_a      <= '0;
            skid_b      <= '0;
            skid_fun    <= '0;
            skid_tag    <= '0;
            err_illegal <= 1'b0;
            issue_cnt   <= '0;
        end else begin
            if (issue) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else begin
                if (accept && illegal) begin
                    err_illegal <= 1'b1;
                end
                // Skid can only be occupied while in_ready is low, so skid drain and accept never collide.
                if (issue) begin
                    if (skid_valid) begin
                        A          <= skid_a;
                        B          <= skid_b;
                        ALUFun     <= skid_fun;
                        out_tag    <= skid_tag;
                        skid_valid <= 1'b0;
                    end else if (accept) begin
                        A       <= cap_a;
                        B       <= cap_b;
                        ALUFun  <= in_alufun;
                        out_tag <= in_tag;
                    end else begin
                        main_valid <= 1'b0;
                    end
                end else if (accept) begin
                    if (!main_valid) begin
                        A          <= cap_a;
                        B          <= cap_b;
                        ALUFun     <= in_alufun;
                        out_tag    <= in_tag;
                        main_valid <= 1'b1;
                    end else begin
                        skid_a     <= cap_a;
                        skid_b     <= cap_b;
                        skid_fun   <= in_alufun;
                        skid_tag   <= in_tag;
                        skid_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic, all checked
// against a queue-based model of the two-entry stage.
module tb_alu_operand_stage;

    localparam int TAG_W = 4;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [5:0]       fun;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [5:0]       in_alufun = '0;
    logic [31:0]      in_rs = '0;
    logic [31:0]      in_rt = '0;
    logic [31:0]      in_imm = '0;
    logic [4:0]       in_shamt = '0;
    logic             in_srca = 1'b0;
    logic             in_srcb = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      A;
    logic [31:0]      B;
    logic [5:0]       ALUFun;
    logic [TAG_W-1:0] out_tag;
    logic             err_illegal;
    logic [15:0]      issue_cnt;

    int checks = 0;
    int errors = 0;

    entry_t           m_q[$];
    logic [TAG_W-1:0] m_issued_tags[$];
    logic             m_err = 1'b0;
    logic [15:0]      m_cnt = '0;

    alu_operand_stage #(.TAG_W(TAG_W), .CHECK_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alufun(in_alufun), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .in_shamt(in_shamt), .in_srca(in_srca), .in_srcb(in_srcb), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALUFun(ALUFun), .out_tag(out_tag),
        .err_illegal(err_illegal), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: an entry's operands follow directly from the instruction fields.
    function automatic entry_t make_entry(input logic [5:0] fun, input logic [31:0] rs, rt, imm,
                                          input logic [4:0] sh, input logic sa, sb,
                                          input logic [TAG_W-1:0] tg);
        entry_t e;
        e.a = sa ? 32'(sh) : rs;
        if (fun[5:4] == 2'b10) e.a = e.a % 32;
        e.b   = sb ? imm : rt;
        e.fun = fun;
        e.tag = tg;
        return e;
    endfunction

    function automatic logic is_illegal(input logic [5:0] fun);
        return (fun[5:4] == 2'b10) && !(fun inside {6'b100000, 6'b100001, 6'b100011});
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_err = 1'b0;
        m_cnt = '0;
    endtask

    // One clock cycle: drive, compare the stage against the model, then advance the model.
    task automatic applyStimulus(input logic v, input logic [5:0] fun, input logic [31:0] rs, rt, imm,
                                 input logic [4:0] sh, input logic sa, sb,
                                 input logic [TAG_W-1:0] tg, input logic ordy, fl,
                                 output logic acc);
        logic iss;
        @(negedge clk);
        in_valid = v; in_alufun = fun; in_rs = rs; in_rt = rt; in_imm = imm;
        in_shamt = sh; in_srca = sa; in_srcb = sb; in_tag = tg; out_ready = ordy; flush = fl;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
        checkOutput("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            checkOutput("A", A, m_q[0].a);
            checkOutput("B", B, m_q[0].b);
            checkOutput("ALUFun", 32'(ALUFun), 32'(m_q[0].fun));
            checkOutput("out_tag", 32'(out_tag), 32'(m_q[0].tag));
        end
        checkOutput("err_illegal", 32'(err_illegal), 32'(m_err));
        checkOutput("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        acc = v && (m_q.size() < 2);
        iss = ordy && (m_q.size() > 0);
        if (iss) begin
            m_cnt = m_cnt + 16'd1;
            m_issued_tags.push_back(m_q[0].tag);
        end
        if (fl) begin
            m_q.delete();
        end else begin
            if (iss) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(make_entry(fun, rs, rt, imm, sh, sa, sb, tg));
                if (is_illegal(fun)) m_err = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, '0, ordy, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   issued_before;
        logic [15:0] cnt_before;

        // Reset state while reset is held low.
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_A", A, 32'd0);
        checkOutput("rst_B", B, 32'd0);
        checkOutput("rst_ALUFun", 32'(ALUFun), 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        checkOutput("rst_err", 32'(err_illegal), 32'd0);
        checkOutput("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] shift capture");
        applyStimulus(1'b1, 6'b100000, 32'hDEADBEEF, 32'hB38F0F83, 32'h0, 5'd8, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, acc);
        #1;
        checkOutput("sh_valid", 32'(out_valid), 32'd1);
        checkOutput("sh_A", A, 32'h00000008);
        checkOutput("sh_B", B, 32'hB38F0F83);
        checkOutput("sh_fun", 32'(ALUFun), 32'h20);
        idle(1, 1'b1);
        #1;
        checkOutput("sh_issue_cnt", 32'(issue_cnt), 32'd1);

        $display("[TB] shift A cleaning and illegal code");
        applyStimulus(1'b1, 6'b100011, 32'hFFFFFFF7, 32'h12345678, 32'h0, 5'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, acc);
        #1;
        checkOutput("clean_A", A, 32'h00000017);
        checkOutput("clean_B", B, 32'h12345678);
        checkOutput("clean_err", 32'(err_illegal), 32'd0);
        applyStimulus(1'b1, 6'b100010, 32'h0, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, acc);
        #1;
        checkOutput("illegal_err", 32'(err_illegal), 32'd1);
        applyStimulus(1'b1, 6'b000000, 32'h7, 32'h9, 32'h0, 5'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, acc);
        #1;
        checkOutput("illegal_sticky", 32'(err_illegal), 32'd1);
        idle(2, 1'b1);

        $display("[TB] backpressure");
        m_issued_tags.delete();
        sent = 0;
        for (int c = 0; c < 30 && !(sent == 4 && m_q.size() == 0); c++) begin
            applyStimulus(sent < 4, 6'b000000, 32'((sent + 1) * 32'h1010), 32'((sent + 1) * 32'h0202),
                          32'h0, 5'd0, 1'b0, 1'b0, 4'(sent + 1), c >= 4, 1'b0, acc);
            if (acc) sent++;
            if (c == 3) begin
                #1;
                checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
                checkOutput("bp_hold_tag", 32'(out_tag), 32'd1);
                checkOutput("bp_hold_A", A, 32'h1010);
            end
        end
        checkOutput("bp_drained", 32'(sent == 4 && m_q.size() == 0), 32'd1);
        checkOutput("bp_issue_count", 32'(m_issued_tags.size()), 32'd4);
        for (int i = 0; i < 4 && i < m_issued_tags.size(); i++)
            checkOutput("bp_order", 32'(m_issued_tags[i]), 32'(i + 1));

        $display("[TB] full throughput");
        cnt_before = m_cnt;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 6'(i), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                          1'($urandom), 4'(i), 1'b1, 1'b0, acc);
            checkOutput("tp_accept", 32'(acc), 32'd1);
            #1;
            checkOutput("tp_in_ready", 32'(in_ready), 32'd1);
            checkOutput("tp_out_valid", 32'(out_valid), 32'd1);
        end
        idle(1, 1'b1);
        #1;
        checkOutput("tp_issue_cnt", 32'(issue_cnt), 32'(cnt_before + 16'd16));

        $display("[TB] flush");
        applyStimulus(1'b1, 6'd1, 32'h11, 32'h22, 32'h0, 5'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 6'd2, 32'h33, 32'h44, 32'h0, 5'd0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 6'd3, 32'h55, 32'h66, 32'h0, 5'd0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, acc);
        #1;
        checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
        checkOutput("fl_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 6'd4, 32'h77, 32'h88, 32'h0, 5'd0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 6'd5, 32'h99, 32'haa, 32'h0, 5'd0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1, acc);
        #1;
        checkOutput("fl2_out_valid", 32'(out_valid), 32'd0);
        idle(3, 1'b1);

        $display("[TB] async reset mid-stream");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 6'b100010, $urandom, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0,
                          4'(i), 1'($urandom), 1'b0, acc);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_A", A, 32'd0);
        checkOutput("arst_B", B, 32'd0);
        checkOutput("arst_err", 32'(err_illegal), 32'd0);
        checkOutput("arst_issue_cnt", 32'(issue_cnt), 32'd0);
        model_reset();
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [5:0] fun;
            case ($urandom_range(0, 5))
                0: fun = 6'b100000;
                1: fun = 6'b100001;
                2: fun = 6'b100011;
                3: fun = (i > 200) ? 6'({2'b10, 4'($urandom)}) : 6'b100000;
                default: fun = 6'($urandom);
            endcase
            applyStimulus($urandom_range(0, 9) < 7, fun, $urandom, $urandom, $urandom, 5'($urandom),
                          1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 9) < 6,
                          $urandom_range(0, 19) == 0, acc);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Registered operand-issue stage that sits directly upstream of the ALU, including its Shift unit. It accepts decoded instruction fields with a valid/ready handshake and selects the A/B operands. For shift ops it forces A to a clean zero-extended shift amount. It presents A, B and ALUFun from registers, and its 2-entry skid buffer gives full throughput under downstream backpressure.

Parameters:
TAG_W, 4, width of the opaque instruction tag carried alongside operands
CHECK_SHIFT, 1, when 1 illegal shift encodings (ALUFun[5:4]==2'b10, not 100000/100001/100011) raise err_illegal

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush, discards all held entries
in_valid  in  1  upstream has an instruction
in_ready  out  1  stage can accept this cycle
in_alufun  in  6  ALU function code
in_rs  in  32  register rs value
in_rt  in  32  register rt value
in_imm  in  32  extended immediate
in_shamt  in  5  instruction shamt field
in_srca  in  1  0: A=rs, 1: A=shamt
in_srcb  in  1  0: B=rt, 1: B=imm
in_tag  in  TAG_W  instruction tag
out_valid  out  1  A/B/ALUFun valid to ALU
out_ready  in  1  ALU/downstream accepts
A  out  32  operand A to ALU
B  out  32  operand B to ALU
ALUFun  out  6  function code to ALU
out_tag  out  TAG_W  tag of presented entry
err_illegal  out  1  sticky illegal-shift flag
issue_cnt  out  16  count of completed output handshakes, wraps

Behaviour:
- Reset (reset==0, async): main/skid valid=0, A=B=0, ALUFun=0, out_tag=0, err_illegal=0, issue_cnt=0, in_ready=1 after release.
- Operand select, applied on capture:
  - A = in_srca ? {27'b0,in_shamt} : in_rs
  - B = in_srcb ? in_imm : in_rt
- Shift ops (in_alufun[5:4]==2'b10): A forced to {27'b0, selected_A[4:0]} regardless of in_srca; B is the value shifted.
- Illegal shift code with CHECK_SHIFT=1: err_illegal set on capture and held until reset. The entry still passes through unchanged.
- Accept = in_valid & in_ready. Issue = out_valid & out_ready.
- in_ready = ~skid_valid (registered, not combinational from out_ready).
- Capture routing on accept:
  - If main empty, or issue this cycle with skid empty: write main.
  - Otherwise: write skid.
- Issue with skid full: skid moves to main the same edge; a simultaneous accept is impossible (in_ready=0).
- Issue with skid empty and no accept: main_valid clears.
- Latency 1 cycle from accept to out_valid. Sustained throughput 1/cycle when out_ready=1.
- Outputs A/B/ALUFun/out_tag hold stable while out_valid=1 and out_ready=0.
- flush=1: main_valid and skid_valid clear on the next edge; any input accepted that cycle is dropped; issue_cnt still counts an issue in that cycle; err_illegal unchanged. Flush wins over all other events.
- issue_cnt increments on every issue and wraps 0xFFFF->0.
- Reset asserted mid-transfer drops all entries immediately; outputs go to reset values asynchronously.

Test Plan:
- Shift capture: in_alufun=100000, in_srca=1, in_shamt=8, in_srcb=0, in_rt=0xB38F0F83, out_ready=1 -> next cycle out_valid=1, A=0x00000008, B=0xB38F0F83, ALUFun=100000, issue_cnt=1.
- Shift A cleaning: in_alufun=100011, in_srca=0, in_rs=0xFFFFFFF7 -> A=0x00000017, B unchanged; in_alufun=100010 -> err_illegal=1 and stays 1 after a later legal op.
- Backpressure: stream 4 entries (tags 1..4) with out_ready=0 -> in_ready drops after 2 accepts, A/B stable at tag 1. Release out_ready -> tags 1,2,3,4 issue in order, no loss or duplication.
- Full throughput: 16 back-to-back entries with out_ready=1 -> 16 consecutive out_valid cycles, in_ready constantly 1, issue_cnt=16.
- Flush: main and skid full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input not issued.
- Async reset: assert reset mid-stream between clock edges -> out_valid=0, A=B=0, err_illegal=0, issue_cnt=0 immediately; normal after release.
